// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: default datapath widths, the NOP encoding
// and the {pc, inst} entry held by pipeline registers.
package cpu_pipe_pkg;

  localparam int          PIPE_ADDR_W   = 32;
  localparam int          PIPE_INST_W   = 32;
  localparam logic [31:0] PIPE_NOP_INST = 32'h0;

  // Stage widths are expected not to exceed these field widths.
  typedef struct packed {
    logic [PIPE_ADDR_W-1:0] pc;
    logic [PIPE_INST_W-1:0] inst;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
// Sticks at all-ones; cleared only by rst.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a 2-entry (main + skid) buffer, registered
// in_ready and flush-to-NOP. Optional counters under IF_ID_SKID_PERF_EN.
module if_id_skid
  import cpu_pipe_pkg::*;
#(
  parameter int                ADDR_W   = PIPE_ADDR_W,
  parameter int                INST_W   = PIPE_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(PIPE_NOP_INST),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_entry_t main_reg, main_next;
  pipe_entry_t skid_reg, skid_next;
  pipe_entry_t in_entry;
  logic        main_valid_reg, main_valid_next;
  logic        skid_valid_reg, skid_valid_next;
  logic        in_ready_reg;
  logic        in_xfer, out_xfer;

  assign in_xfer       = in_valid && in_ready_reg;
  assign out_xfer      = main_valid_reg && out_ready;
  assign in_entry.pc   = PIPE_ADDR_W'(in_pc);
  assign in_entry.inst = PIPE_INST_W'(in_inst);

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      // Squash everything; pc is left as-is so decode sees a stable address.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
      main_next.inst  = PIPE_INST_W'(NOP_INST);
    end else if (!main_valid_reg) begin
      if (in_xfer) begin
        main_next       = in_entry;
        main_valid_next = 1'b1;
      end
    end else if (out_xfer) begin
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        skid_valid_next = 1'b0;
      end else if (in_xfer) begin
        main_next = in_entry;
      end else begin
        main_valid_next = 1'b0;
        main_next.inst  = PIPE_INST_W'(NOP_INST);
      end
    end else if (in_xfer) begin
      skid_next       = in_entry;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg.pc    <= '0;
      main_reg.inst  <= PIPE_INST_W'(NOP_INST);
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      // Registered from next skid state: no path from out_ready to in_ready.
      in_ready_reg   <= !skid_valid_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid_reg;
  assign out_pc    = ADDR_W'(main_reg.pc);
  assign out_inst  = INST_W'(main_reg.inst);

`ifdef IF_ID_SKID_PERF_EN
  logic [1:0]       perf_inc;
  logic [CNT_W-1:0] perf_cnt [2];

  assign perf_inc[0] = main_valid_reg && !out_ready;
  assign perf_inc[1] = !main_valid_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    pipe_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (perf_inc[gi]),
      .count (perf_cnt[gi])
    );
  end

  assign stall_cnt  = perf_cnt[0];
  assign bubble_cnt = perf_cnt[1];
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed vector table plus random traffic, all
// checked against a FIFO scoreboard of accepted {pc, inst} pairs.
module tb_if_id_skid;

  localparam int          AW    = 32;
  localparam int          IW    = 32;
  localparam int          CW    = 4;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [AW-1:0] in_pc, out_pc;
  logic [IW-1:0] in_inst, out_inst;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  if_id_skid #(.ADDR_W(AW), .INST_W(IW), .NOP_INST(NOP_I), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [AW-1:0] pc;
    logic          ordy;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
    logic          exp_ready;
  } vec_t;

  ent_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk_inst(input logic [AW-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // One clock: drive inputs, clock, update scoreboard, check DUT state.
  task automatic step(input logic fl, input logic iv, input logic [AW-1:0] pc,
                      input logic ordy, input bit verbose);
    logic ix, ox;
    ent_t e;
    flush = fl; in_valid = iv; in_pc = pc; in_inst = mk_inst(pc); out_ready = ordy;
    #1;
    ix = iv && in_ready;
    ox = out_valid && ordy;
    @(posedge clk); #1;
    if (fl) sb_q.delete();
    else begin
      if (ox && sb_q.size() > 0) void'(sb_q.pop_front());
      if (ix) begin e.pc = pc; e.inst = mk_inst(pc); sb_q.push_back(e); end
    end
    chk("sb_out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
    chk("sb_in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
    if (sb_q.size() > 0) begin
      chk("sb_out_pc", 64'(out_pc), 64'(sb_q[0].pc));
      chk("sb_out_inst", 64'(out_inst), 64'(sb_q[0].inst));
    end else begin
      chk("sb_nop_inst", 64'(out_inst), 64'(NOP_I));
    end
    if (verbose)
      $display("txn fl=%0b iv=%0b pc=%0h ordy=%0b -> ov=%0b opc=%0h oinst=%0h ir=%0b",
               fl, iv, pc, ordy, out_valid, out_pc, out_inst, in_ready);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 32'hDEAD; in_inst = 32'hBEEF;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
  endtask

  vec_t vt[$];

  initial begin
    // Directed table: rows run back-to-back from an empty stage.
    vt = '{
      '{0,1,32'h100,1, 1,32'h100,1}, '{0,1,32'h104,1, 1,32'h104,1},
      '{0,1,32'h108,1, 1,32'h108,1}, '{0,0,32'h0,  1, 0,32'h0,  1},
      '{0,1,32'h200,0, 1,32'h200,1}, '{0,1,32'h204,0, 1,32'h200,0},
      '{0,1,32'h208,0, 1,32'h200,0}, '{0,0,32'h0,  1, 1,32'h204,1},
      '{0,0,32'h0,  1, 0,32'h0,  1},
      '{0,1,32'h300,0, 1,32'h300,1}, '{0,1,32'h304,0, 1,32'h300,0},
      '{1,1,32'h308,0, 0,32'h0,  1}, '{0,0,32'h0,  1, 0,32'h0,  1},
      '{0,1,32'h310,1, 1,32'h310,1}, '{1,1,32'h314,1, 0,32'h0,  1},
      '{0,0,32'h0,  1, 0,32'h0,  1},
      '{0,1,32'h320,0, 1,32'h320,1}, '{0,1,32'h324,0, 1,32'h320,0},
      '{0,1,32'h328,1, 1,32'h324,1}, '{0,1,32'h32C,1, 1,32'h32C,1},
      '{0,0,32'h0,  1, 0,32'h0,  1}
    };

    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'(NOP_I));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    $display("txn reset -> ov=%0b opc=%0h oinst=%0h ir=%0b", out_valid, out_pc, out_inst, in_ready);

    foreach (vt[i]) begin
      step(vt[i].fl, vt[i].iv, vt[i].pc, vt[i].ordy, 1'b1);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].exp_valid));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].exp_ready));
      if (vt[i].exp_valid) chk($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(vt[i].exp_pc));
      else chk($sformatf("vec%0d_nop", i), 64'(out_inst), 64'(NOP_I));
    end

    // Random traffic; in_ready must not move when out_ready toggles mid-cycle.
    for (int n = 0; n < 10000; n++) begin
      logic fl, iv, ordy, r0;
      fl   = ($urandom_range(63) == 0);
      iv   = ($urandom_range(9) < 7);
      ordy = ($urandom_range(9) < 6);
      out_ready = ~ordy; #1; r0 = in_ready;
      out_ready = ordy;  #1;
      if (r0 !== in_ready) chk("in_ready_comb_path", 64'(in_ready), 64'(r0));
      step(fl, iv, 32'h1000 + 32'(n) * 4, ordy, 1'b0);
    end
    $display("txn random done: %0d checks so far", checks);

`ifdef IF_ID_SKID_PERF_EN
    do_reset();
    chk("perf_rst_stall", 64'(stall_cnt), 64'd0);
    step(0, 1, 32'h400, 0, 1'b1);
    repeat (20) step(0, 0, 32'h0, 0, 1'b0);
    chk("perf_stall_sat", 64'(stall_cnt), 64'd15);
    step(1, 0, 32'h0, 0, 1'b1);
    chk("perf_flush_keeps", 64'(stall_cnt), 64'd15);
    do_reset();
    chk("perf_rst_clear_stall", 64'(stall_cnt), 64'd0);
    chk("perf_rst_clear_bubble", 64'(bubble_cnt), 64'd0);
    repeat (3) step(0, 0, 32'h0, 1, 1'b1);
    chk("perf_bubble_count", 64'(bubble_cnt), 64'd3);
`else
    chk("perf_stall_tied", 64'(stall_cnt), 64'd0);
    chk("perf_bubble_tied", 64'(bubble_cnt), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
